// File: rtl/padovan_pkg.sv
// Shared definitions for the Padovan datapath.
// Contents:
//   reg_sel_e : read/write decode codes for the register bank
//   alu_op_e  : ALU opcodes
package padovan_pkg;

    // Register decode. Reads use every code.
    // For writes, codes above REG_R4 mean "no write".
    typedef enum logic [2:0] {
        REG_R0   = 3'b000,
        REG_R1   = 3'b001,
        REG_R2   = 3'b010,
        REG_R3   = 3'b011,
        REG_R4   = 3'b100,
        REG_RP1  = 3'b101,
        REG_RP0  = 3'b110,
        REG_NONE = 3'b111
    } reg_sel_e;

    // ALU opcodes (Y computed from bus A and bus B).
    typedef enum logic [2:0] {
        ALU_PASS = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_AND  = 3'b011,
        ALU_OR   = 3'b100,
        ALU_XOR  = 3'b101,
        ALU_INC  = 3'b110,
        ALU_DEC  = 3'b111
    } alu_op_e;

    // Number of working registers R0..R4.
    localparam int NUM_WORK_REGS = 5;

endpackage

// File: rtl/padovan_datapath_alu.sv
// Combinational ALU for the Padovan datapath.
// Ports:
//   a_i, b_i     : operands (bus A, bus B)
//   op_i         : opcode (alu_op_e)
//   y_o          : result, modulo 2^DATA_WIDTH
//   overflow_o   : two's-complement overflow (arithmetic ops only)
//   carry_o      : carry out for add/inc, borrow for sub/dec
//   negative_o   : MSB of y_o
//   zero_o       : y_o == 0
module padovan_alu
    import padovan_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int SELECTIONALU = 3
) (
    input  logic [DATA_WIDTH-1:0]   a_i,
    input  logic [DATA_WIDTH-1:0]   b_i,
    input  logic [SELECTIONALU-1:0] op_i,
    output logic [DATA_WIDTH-1:0]   y_o,
    output logic                    overflow_o,
    output logic                    carry_o,
    output logic                    negative_o,
    output logic                    zero_o
);

    localparam int MSB = DATA_WIDTH - 1;

    logic [DATA_WIDTH-1:0] b_arith;
    logic [DATA_WIDTH:0]   ext_add;
    logic [DATA_WIDTH:0]   ext_sub;

    // INC/DEC reuse the add/sub paths with a constant 1 as the second operand,
    // so the carry/borrow and overflow rules are shared.
    always_comb begin
        b_arith = ((op_i == ALU_INC) || (op_i == ALU_DEC)) ? DATA_WIDTH'(1) : b_i;
        // The extra top bit is the carry for add and the borrow for sub.
        ext_add = {1'b0, a_i} + {1'b0, b_arith};
        ext_sub = {1'b0, a_i} - {1'b0, b_arith};
    end

    always_comb begin
        y_o        = '0;
        carry_o    = 1'b0;
        overflow_o = 1'b0;
        case (op_i)
            ALU_PASS: y_o = a_i;
            ALU_ADD, ALU_INC: begin
                y_o        = ext_add[DATA_WIDTH-1:0];
                carry_o    = ext_add[DATA_WIDTH];
                // Same-sign operands giving a different-sign result.
                overflow_o = (a_i[MSB] == b_arith[MSB]) && (y_o[MSB] != a_i[MSB]);
            end
            ALU_SUB, ALU_DEC: begin
                y_o        = ext_sub[DATA_WIDTH-1:0];
                carry_o    = ext_sub[DATA_WIDTH];
                // Opposite-sign operands with the result sign differing from A.
                overflow_o = (a_i[MSB] != b_arith[MSB]) && (y_o[MSB] != a_i[MSB]);
            end
            ALU_AND: y_o = a_i & b_i;
            ALU_OR:  y_o = a_i | b_i;
            ALU_XOR: y_o = a_i ^ b_i;
            default: y_o = a_i;
        endcase
    end

    assign negative_o = y_o[MSB];
    assign zero_o     = (y_o == '0);

endmodule

// File: rtl/padovan_datapath.sv
// Register bank + ALU datapath executing one micro-op per clock.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   sSelDecoA/B            : read-port selects (R0..R4, RP1, RP0, constant 0)
//   sSelDecoC              : write select (R0..R4; other codes = no write)
//   sSelAlu                : ALU opcode
//   prog_we/sel/data       : program register load (sel 0 = RP0, 1 = RP1)
//   sOverflow/sCarry/
//   sNegative/sZero        : combinational flags of the current ALU op
//   out_data, out_valid    : registered copy of every value written to R3,
//                            with a one-cycle valid pulse
module padovan_datapath
    import padovan_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int SELECTIONALU  = 3,
    parameter int SELECTIONDECO = 3,
    parameter int RP0_RESET     = 1,
    parameter int RP1_RESET     = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SELECTIONDECO-1:0] sSelDecoA,
    input  logic [SELECTIONDECO-1:0] sSelDecoB,
    input  logic [SELECTIONDECO-1:0] sSelDecoC,
    input  logic [SELECTIONALU-1:0]  sSelAlu,
    input  logic                     prog_we,
    input  logic                     prog_sel,
    input  logic [DATA_WIDTH-1:0]    prog_data,
    output logic                     sOverflow,
    output logic                     sCarry,
    output logic                     sNegative,
    output logic                     sZero,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_valid
);

    logic [DATA_WIDTH-1:0] r_q [NUM_WORK_REGS];
    logic [DATA_WIDTH-1:0] r_d [NUM_WORK_REGS];
    logic [DATA_WIDTH-1:0] rp0_q, rp0_d;
    logic [DATA_WIDTH-1:0] rp1_q, rp1_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;

    logic [DATA_WIDTH-1:0] bus_a;
    logic [DATA_WIDTH-1:0] bus_b;
    logic [DATA_WIDTH-1:0] alu_y;

    // Read muxes: both ports decode identically. Reads always see the
    // registered values, so a same-cycle write is not bypassed.
    always_comb begin
        bus_a = '0;
        case (sSelDecoA)
            REG_R0:   bus_a = r_q[0];
            REG_R1:   bus_a = r_q[1];
            REG_R2:   bus_a = r_q[2];
            REG_R3:   bus_a = r_q[3];
            REG_R4:   bus_a = r_q[4];
            REG_RP1:  bus_a = rp1_q;
            REG_RP0:  bus_a = rp0_q;
            default:  bus_a = '0;
        endcase
    end

    always_comb begin
        bus_b = '0;
        case (sSelDecoB)
            REG_R0:   bus_b = r_q[0];
            REG_R1:   bus_b = r_q[1];
            REG_R2:   bus_b = r_q[2];
            REG_R3:   bus_b = r_q[3];
            REG_R4:   bus_b = r_q[4];
            REG_RP1:  bus_b = rp1_q;
            REG_RP0:  bus_b = rp0_q;
            default:  bus_b = '0;
        endcase
    end

    padovan_alu #(
        .DATA_WIDTH   (DATA_WIDTH),
        .SELECTIONALU (SELECTIONALU)
    ) u_alu (
        .a_i        (bus_a),
        .b_i        (bus_b),
        .op_i       (sSelAlu),
        .y_o        (alu_y),
        .overflow_o (sOverflow),
        .carry_o    (sCarry),
        .negative_o (sNegative),
        .zero_o     (sZero)
    );

    // Write decoder: codes beyond R4 leave the bank untouched.
    always_comb begin
        for (int i = 0; i < NUM_WORK_REGS; i++) begin
            r_d[i] = r_q[i];
            if (sSelDecoC == SELECTIONDECO'(i)) begin
                r_d[i] = alu_y;
            end
        end
    end

    // Program registers live in separate storage, so a load can coincide
    // with any C write.
    always_comb begin
        rp0_d = rp0_q;
        rp1_d = rp1_q;
        if (prog_we) begin
            if (prog_sel) rp1_d = prog_data;
            else          rp0_d = prog_data;
        end
    end

    // Every R3 write is a new series term and is streamed out.
    always_comb begin
        out_valid_d = (sSelDecoC == REG_R3);
        out_data_d  = out_valid_d ? alu_y : out_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_WORK_REGS; i++) begin
                r_q[i] <= '0;
            end
            rp0_q       <= DATA_WIDTH'(RP0_RESET);
            rp1_q       <= DATA_WIDTH'(RP1_RESET);
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_WORK_REGS; i++) begin
                r_q[i] <= r_d[i];
            end
            rp0_q       <= rp0_d;
            rp1_q       <= rp1_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_padovan_datapath.sv
module tb_padovan_datapath;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    sel_a, sel_b, sel_c, alu_op;
  logic          prog_we, prog_sel;
  logic [DW-1:0] prog_data;
  logic          f_ovf, f_carry, f_neg, f_zero;
  logic [DW-1:0] out_data;
  logic          out_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  int m_r [5];
  int m_rp0, m_rp1, m_out, m_valid;

  // Flags seen on the last step (for directed checks)
  int last_ovf, last_carry, last_neg, last_zero;

  padovan_datapath dut (
    .clk       (clk),
    .rst       (rst),
    .sSelDecoA (sel_a),
    .sSelDecoB (sel_b),
    .sSelDecoC (sel_c),
    .sSelAlu   (alu_op),
    .prog_we   (prog_we),
    .prog_sel  (prog_sel),
    .prog_data (prog_data),
    .sOverflow (f_ovf),
    .sCarry    (f_carry),
    .sNegative (f_neg),
    .sZero     (f_zero),
    .out_data  (out_data),
    .out_valid (out_valid)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int to_signed(input int v);
    return (v > 127) ? v - 256 : v;
  endfunction

  function automatic int model_read(input logic [2:0] s);
    case (s)
      3'd5:    return m_rp1;
      3'd6:    return m_rp0;
      3'd7:    return 0;
      default: return m_r[s];
    endcase
  endfunction

  // Plain-arithmetic reference for the ALU result and flags.
  task automatic model_alu(input logic [2:0] op, input int a, input int b,
                           output int y, output int ov, output int cy,
                           output int arith);
    int sr;
    sr = 0; cy = 0; arith = 1;
    case (op)
      3'd0: begin y = a;            arith = 0; end
      3'd1: begin y = (a - b) & 255; cy = (a < b);      sr = to_signed(a) - to_signed(b); end
      3'd2: begin y = (a + b) & 255; cy = (a + b > 255); sr = to_signed(a) + to_signed(b); end
      3'd3: begin y = a & b;        arith = 0; end
      3'd4: begin y = a | b;        arith = 0; end
      3'd5: begin y = a ^ b;        arith = 0; end
      3'd6: begin y = (a + 1) & 255; cy = (a == 255);   sr = to_signed(a) + 1; end
      default: begin y = (a - 1) & 255; cy = (a == 0);  sr = to_signed(a) - 1; end
    endcase
    ov = arith ? int'(sr < -128 || sr > 127) : 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_r[i] = 0;
    m_rp0 = 1; m_rp1 = 10; m_out = 0; m_valid = 0;
  endtask

  // ---------------- driver + compare ----------------
  // One micro-op: drive after the falling edge, compare flags before the
  // rising edge, advance the model at the edge, compare outputs just after.
  task automatic step(input logic [2:0] a, input logic [2:0] b,
                      input logic [2:0] c, input logic [2:0] op,
                      input logic pwe, input logic psel,
                      input logic [DW-1:0] pd, input logic r);
    int y, ov, cy, arith;
    @(negedge clk);
    sel_a = a; sel_b = b; sel_c = c; alu_op = op;
    prog_we = pwe; prog_sel = psel; prog_data = pd; rst = r;
    #1;
    model_alu(op, model_read(a), model_read(b), y, ov, cy, arith);
    last_ovf = int'(f_ovf); last_carry = int'(f_carry);
    last_neg = int'(f_neg); last_zero = int'(f_zero);
    chk("sZero", last_zero, int'(y == 0));
    chk("sNegative", last_neg, int'(y >= 128));
    chk("sOverflow", last_ovf, ov);
    if (arith != 0) chk("sCarry", last_carry, cy);
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (c < 3'd5) m_r[c] = y;
      if (pwe) begin
        if (psel) m_rp1 = int'(pd);
        else      m_rp0 = int'(pd);
      end
      m_valid = int'(c == 3'd3);
      if (c == 3'd3) m_out = y;
    end
    #1;
    chk("out_data", int'(out_data), m_out);
    chk("out_valid", int'(out_valid), m_valid);
  endtask

  task automatic uop(input logic [2:0] a, input logic [2:0] b,
                     input logic [2:0] c, input logic [2:0] op);
    step(a, b, c, op, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; sel_a = 3'd7; sel_b = 3'd7; sel_c = 3'd7; alu_op = 3'd0;
    prog_we = 1'b0; prog_sel = 1'b0; prog_data = '0;
    model_reset();

    // Reset state
    step(3'd7, 3'd7, 3'd7, 3'd0, 1'b0, 1'b0, 8'h00, 1'b1);
    step(3'd7, 3'd7, 3'd7, 3'd0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("reset out_data", int'(out_data), 0);
    chk("reset out_valid", int'(out_valid), 0);

    // 1: RP0 seed and RP1 term count visible after reset
    uop(3'd6, 3'd7, 3'd3, 3'd0);
    chk("t1 zero", last_zero, 0);
    chk("t1 rp0", int'(out_data), 1);
    chk("t1 valid", int'(out_valid), 1);
    uop(3'd5, 3'd7, 3'd3, 3'd0);
    chk("t1 rp1", int'(out_data), 10);
    uop(3'd7, 3'd7, 3'd7, 3'd0);
    chk("t1 valid low", int'(out_valid), 0);

    // 2: program load, same-cycle read sees old value
    step(3'd5, 3'd7, 3'd3, 3'd0, 1'b1, 1'b1, 8'd7, 1'b0);
    chk("t2 old rp1", int'(out_data), 10);
    uop(3'd5, 3'd7, 3'd3, 3'd0);
    chk("t2 new rp1", int'(out_data), 7);

    // 3: Padovan init R0=R1=R2=1, then R3 = R0 + R1
    uop(3'd6, 3'd7, 3'd0, 3'd0);
    uop(3'd6, 3'd7, 3'd1, 3'd0);
    uop(3'd6, 3'd7, 3'd2, 3'd0);
    uop(3'd0, 3'd1, 3'd3, 3'd2);
    chk("t3 term", int'(out_data), 2);
    chk("t3 valid", int'(out_valid), 1);
    uop(3'd7, 3'd7, 3'd7, 3'd0);
    chk("t3 pulse", int'(out_valid), 0);
    chk("t3 hold", int'(out_data), 2);

    // 4: 0 - 1 borrow, and equal operands give zero
    uop(3'd7, 3'd0, 3'd3, 3'd1);
    chk("t4 result", int'(out_data), 8'hFF);
    chk("t4 carry", last_carry, 1);
    chk("t4 neg", last_neg, 1);
    chk("t4 zero", last_zero, 0);
    uop(3'd0, 3'd0, 3'd7, 3'd1);
    chk("t4 zero eq", last_zero, 1);

    // 5: 7F+1 overflow, FF+FF carry
    step(3'd7, 3'd7, 3'd7, 3'd0, 1'b1, 1'b0, 8'h7F, 1'b0);
    uop(3'd6, 3'd7, 3'd0, 3'd0);
    uop(3'd0, 3'd7, 3'd3, 3'd6);
    chk("t5 inc", int'(out_data), 8'h80);
    chk("t5 ovf", last_ovf, 1);
    chk("t5 neg", last_neg, 1);
    uop(3'd7, 3'd7, 3'd0, 3'd7);
    uop(3'd0, 3'd0, 3'd3, 3'd2);
    chk("t5 add", int'(out_data), 8'hFE);
    chk("t5 carry", last_carry, 1);

    // 6: reset beats a same-cycle write; read-while-write sees old value
    step(3'd6, 3'd7, 3'd0, 3'd0, 1'b1, 1'b0, 8'h55, 1'b1);
    uop(3'd0, 3'd7, 3'd7, 3'd0);
    chk("t6 r0 reset", last_zero, 1);
    uop(3'd6, 3'd7, 3'd0, 3'd0);
    uop(3'd0, 3'd7, 3'd0, 3'd7);
    chk("t6 old r0", last_zero, 1);
    uop(3'd0, 3'd7, 3'd3, 3'd0);
    chk("t6 new r0", int'(out_data), 0);

    // Randomized micro-ops against the model
    for (int i = 0; i < 600; i++) begin
      step(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)), ($urandom_range(0, 59) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
